// File: rtl/mole_round_ctrl_if.sv
// Bundles the key/start inputs and the LED/score/status outputs of the
// Whack-A-Mole round controller into one port.
// Ports: start, key_n (to controller); mole_led, score, misses, game_over,
//        hit_pulse, miss_pulse (from controller).
interface mole_round_ctrl_if #(
  parameter int NUM_MOLES = 4,
  parameter int SCORE_W   = 8
);
  logic                 start;
  logic [NUM_MOLES-1:0] key_n;
  logic [NUM_MOLES-1:0] mole_led;
  logic [SCORE_W-1:0]   score;
  logic [3:0]           misses;
  logic                 game_over;
  logic                 hit_pulse;
  logic                 miss_pulse;

  // Stimulus / board side: drives start and keys, observes game outputs.
  modport master (
    output start, key_n,
    input  mole_led, score, misses, game_over, hit_pulse, miss_pulse
  );

  // Controller side.
  modport slave (
    input  start, key_n,
    output mole_led, score, misses, game_over, hit_pulse, miss_pulse
  );
endinterface

// File: rtl/mole_round_ctrl.sv
// Purpose: Whack-A-Mole sequencer: raises one mole at a time, scores key presses, ends game after MAX_MISSES.
// Latency: a press sampled in cycle N updates pulses, score/misses and LEDs in cycle N+1.
// Backpressure: none; keys and start are sampled every cycle, outputs are registered levels/strobes.
//
// Ports: clk, rst (sync, active-high); bus (mole_round_ctrl_if.slave):
//   start, key_n[NUM_MOLES] in; mole_led[NUM_MOLES], score[SCORE_W], misses[4],
//   game_over, hit_pulse, miss_pulse out.
// Build option: define SPEEDUP_EN to shrink the hit window by STEP_TICKS per point,
//   floored at MIN_UP_TICKS; otherwise the window is fixed at UP_TICKS.
module mole_round_ctrl #(
  parameter int          NUM_MOLES    = 4,
  parameter int          UP_TICKS     = 25_000_000,
  parameter int          GAP_TICKS    = 12_500_000,
  parameter int          MAX_MISSES   = 3,
  parameter int          SCORE_W      = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          STEP_TICKS   = 1_000_000,
  parameter int          MIN_UP_TICKS = 5_000_000
) (
  input  logic             clk,
  input  logic             rst,
  mole_round_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_MOLES);

  // Elaboration-time sanity checks on the configuration.
  if (NUM_MOLES < 2 || NUM_MOLES > 16 || (1 << IDX_W) != NUM_MOLES) begin : g_bad_num_moles
    $error("NUM_MOLES must be a power of 2 in 2..16");
  end
  if (MAX_MISSES < 1 || MAX_MISSES > 15) begin : g_bad_max_misses
    $error("MAX_MISSES must be in 1..15");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("LFSR_SEED must be non-zero");
  end
  if (UP_TICKS < 1 || GAP_TICKS < 1 || MIN_UP_TICKS < 1 || MIN_UP_TICKS > UP_TICKS || STEP_TICKS < 0)
  begin : g_bad_ticks
    $error("tick parameters out of range");
  end

  typedef enum logic [1:0] {IDLE, GAP, UP, OVER} state_e;

  state_e               state_q, state_d;
  logic [31:0]          timer_q, timer_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [NUM_MOLES-1:0] prev_key_q, prev_key_d;
  logic [IDX_W-1:0]     last_idx_q, last_idx_d;
  logic [NUM_MOLES-1:0] mole_led_q, mole_led_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [3:0]           misses_q, misses_d;
  logic                 game_over_q, game_over_d;
  logic                 hit_pulse_q, hit_pulse_d;
  logic                 miss_pulse_q, miss_pulse_d;

  logic [NUM_MOLES-1:0] press;
  logic [IDX_W-1:0]     new_idx;
  logic                 gap_done;
  logic [31:0]          up_last;   // timer value of the last cycle of the hit window

  assign press    = ~bus.key_n & prev_key_q;
  assign gap_done = (timer_q == 32'(GAP_TICKS - 1));

`ifdef SPEEDUP_EN
  // Window is latched on the GAP->UP transition so a point scored mid-game
  // only affects the next mole.
  logic [31:0] win_q, win_d, shrink, win_entry;

  always_comb begin
    shrink    = 32'(score_q) * 32'(STEP_TICKS);
    win_entry = 32'(MIN_UP_TICKS);
    if (shrink < 32'(UP_TICKS) && (32'(UP_TICKS) - shrink) > 32'(MIN_UP_TICKS)) begin
      win_entry = 32'(UP_TICKS) - shrink;
    end
    win_d = win_q;
    if (state_q == GAP && gap_done) begin
      win_d = win_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) win_q <= 32'(UP_TICKS);
    else     win_q <= win_d;
  end

  assign up_last = win_q - 32'd1;
`else
  assign up_last = 32'(UP_TICKS - 1);
`endif

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    // Fibonacci LFSR, taps 16,14,13,11, free-running in every state.
    lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    prev_key_d   = bus.key_n;
    last_idx_d   = last_idx_q;
    mole_led_d   = mole_led_q;
    score_d      = score_q;
    misses_d     = misses_q;
    game_over_d  = game_over_q;
    hit_pulse_d  = 1'b0;
    miss_pulse_d = 1'b0;

    // Avoid showing the same hole twice in a row.
    new_idx = lfsr_q[IDX_W-1:0];
    if (new_idx == last_idx_q) begin
      new_idx = new_idx + IDX_W'(1);
    end

    case (state_q)
      IDLE: begin
        mole_led_d = '0;
        if (bus.start) begin
          state_d  = GAP;
          score_d  = '0;
          misses_d = '0;
          timer_d  = '0;
        end
      end

      GAP: begin
        if (gap_done) begin
          state_d    = UP;
          timer_d    = '0;
          last_idx_d = new_idx;
          mole_led_d = NUM_MOLES'(1) << new_idx;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      UP: begin
        if (press[last_idx_q]) begin
          // Correct key wins over a simultaneous wrong key or timeout.
          hit_pulse_d = 1'b1;
          if (score_q != '1) score_d = score_q + SCORE_W'(1);
          mole_led_d  = '0;
          timer_d     = '0;
          state_d     = GAP;
        end else if ((|press) || (timer_q == up_last)) begin
          miss_pulse_d = 1'b1;
          misses_d     = misses_q + 4'd1;
          mole_led_d   = '0;
          timer_d      = '0;
          if ((misses_q + 4'd1) == 4'(MAX_MISSES)) begin
            state_d     = OVER;
            game_over_d = 1'b1;
            mole_led_d  = '1;
          end else begin
            state_d = GAP;
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      OVER: begin
        if (bus.start) begin
          state_d     = GAP;
          score_d     = '0;
          misses_d    = '0;
          game_over_d = 1'b0;
          mole_led_d  = '0;
          timer_d     = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      lfsr_q       <= LFSR_SEED;
      prev_key_q   <= '1;
      last_idx_q   <= '0;
      mole_led_q   <= '0;
      score_q      <= '0;
      misses_q     <= '0;
      game_over_q  <= 1'b0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      lfsr_q       <= lfsr_d;
      prev_key_q   <= prev_key_d;
      last_idx_q   <= last_idx_d;
      mole_led_q   <= mole_led_d;
      score_q      <= score_d;
      misses_q     <= misses_d;
      game_over_q  <= game_over_d;
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
    end
  end

  assign bus.mole_led   = mole_led_q;
  assign bus.score      = score_q;
  assign bus.misses     = misses_q;
  assign bus.game_over  = game_over_q;
  assign bus.hit_pulse  = hit_pulse_q;
  assign bus.miss_pulse = miss_pulse_q;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Purpose: self-checking bench for mole_round_ctrl against a behavioural game model.
// Latency: outputs compared 1 time unit after every rising clk edge.
// Backpressure: none; stimulus is driven every cycle.
module tb_mole_round_ctrl;
  localparam int          NM    = 4;
  localparam int          UPT   = 20;
  localparam int          GAPT  = 5;
  localparam int          MAXM  = 3;
  localparam int          SW    = 8;
  localparam int          STEP  = 4;
  localparam int          MINUP = 8;
  localparam logic [15:0] SEED  = 16'hACE1;

  localparam int P_IDLE = 0, P_GAP = 1, P_UP = 2, P_OVER = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mole_round_ctrl_if #(.NUM_MOLES(NM), .SCORE_W(SW)) bus ();

  mole_round_ctrl #(
    .NUM_MOLES(NM), .UP_TICKS(UPT), .GAP_TICKS(GAPT), .MAX_MISSES(MAXM),
    .SCORE_W(SW), .LFSR_SEED(SEED), .STEP_TICKS(STEP), .MIN_UP_TICKS(MINUP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Game model: phase, cycles spent in phase, window of current mole.
  int          m_phase, m_cnt, m_win, m_score, m_miss, m_last;
  logic [NM-1:0] m_leds, m_prev;
  bit          m_over, m_hit, m_missp;
  logic [15:0] m_lfsr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int win_for(input int s);
    int w;
    w = UPT - s * STEP;
    if (w < MINUP) w = MINUP;
`ifndef SPEEDUP_EN
    w = UPT;
`endif
    return w;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    // taps 16,14,13,11 -> bit positions 15,13,12,10 -> mask B400
    return {v[14:0], ^(v & 16'hB400)};
  endfunction

  task automatic model_step(input bit r, input bit s, input logic [NM-1:0] k);
    logic [NM-1:0] pressed;
    logic [15:0]   cur;
    int            idx;
    if (r) begin
      m_phase = P_IDLE; m_cnt = 0; m_win = UPT; m_score = 0; m_miss = 0; m_last = 0;
      m_leds = '0; m_prev = '1; m_over = 0; m_hit = 0; m_missp = 0; m_lfsr = SEED;
      return;
    end
    pressed = ~k & m_prev;
    m_prev  = k;
    cur     = m_lfsr;
    m_lfsr  = lfsr_next(m_lfsr);
    m_hit   = 0;
    m_missp = 0;
    case (m_phase)
      P_IDLE: if (s) begin m_phase = P_GAP; m_cnt = 0; m_score = 0; m_miss = 0; end
      P_GAP: begin
        if (m_cnt == GAPT - 1) begin
          idx = int'(cur) % NM;
          if (idx == m_last) idx = (idx + 1) % NM;
          m_last = idx; m_leds = NM'(1 << idx);
          m_phase = P_UP; m_cnt = 0; m_win = win_for(m_score);
        end else m_cnt++;
      end
      P_UP: begin
        if (pressed[m_last]) begin
          m_hit = 1; if (m_score < (1 << SW) - 1) m_score++;
          m_leds = '0; m_phase = P_GAP; m_cnt = 0;
        end else if (pressed != '0 || m_cnt == m_win - 1) begin
          m_missp = 1; m_miss++; m_leds = '0; m_cnt = 0;
          if (m_miss == MAXM) begin m_phase = P_OVER; m_over = 1; m_leds = '1; end
          else m_phase = P_GAP;
        end else m_cnt++;
      end
      default: if (s) begin
        m_phase = P_GAP; m_cnt = 0; m_score = 0; m_miss = 0; m_over = 0; m_leds = '0;
      end
    endcase
  endtask

  task automatic tick(input bit r, input bit s, input logic [NM-1:0] k);
    rst = r; bus.start = s; bus.key_n = k;
    @(posedge clk);
    model_step(r, s, k);
    #1;
    chk("mole_led",   32'(bus.mole_led),   32'(m_leds));
    chk("score",      32'(bus.score),      32'(m_score));
    chk("misses",     32'(bus.misses),     32'(m_miss));
    chk("game_over",  32'(bus.game_over),  32'(m_over));
    chk("hit_pulse",  32'(bus.hit_pulse),  32'(m_hit));
    chk("miss_pulse", 32'(bus.miss_pulse), 32'(m_missp));
  endtask

  function automatic logic [NM-1:0] press_of(input int i);
    logic [NM-1:0] k;
    k = '1;
    k[i] = 1'b0;
    return k;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    int            zeros, uplen, npulse;
    bit            first;
    logic [NM-1:0] k, kprev;
    bus.start = 1'b0;
    bus.key_n = '1;

    // Reset state
    tick(1, 0, '1);
    tick(1, 0, '1);
    chk("rst_led", 32'(bus.mole_led), 32'd0);
    chk("rst_score", 32'(bus.score), 32'd0);
    chk("rst_over", 32'(bus.game_over), 32'd0);

    // Start: five dark GAP cycles, then exactly one mole
    tick(0, 1, '1);
    zeros = (bus.mole_led == '0) ? 1 : 0;
    for (int i = 0; i < 10 && bus.mole_led == '0; i++) begin
      tick(0, 0, '1);
      if (bus.mole_led == '0) zeros++;
    end
    chk("gap_len", 32'(zeros), 32'd5);
    chk("onehot", 32'($onehot(bus.mole_led)), 32'd1);

    // Correct key a few cycles into UP
    tick(0, 0, '1);
    tick(0, 0, '1);
    tick(0, 0, press_of(m_last));
    chk("hit_pulse_d", 32'(bus.hit_pulse), 32'd1);
    chk("hit_score", 32'(bus.score), 32'd1);
    chk("hit_led_off", 32'(bus.mole_led), 32'd0);
    tick(0, 0, '1);

    // Three timeouts end the game; first window length measured
    npulse = 0; uplen = 0; first = 1;
    for (int i = 0; i < 300 && !bus.game_over; i++) begin
      tick(0, 0, '1);
      if (bus.miss_pulse) begin npulse++; first = 0; end
      else if (first && bus.mole_led != '0) uplen++;
    end
    chk("win_s1", 32'(uplen), 32'(win_for(1)));
    chk("miss_cnt", 32'(npulse), 32'd3);
    chk("over_flag", 32'(bus.game_over), 32'd1);
    chk("over_led", 32'(bus.mole_led), 32'hF);
    chk("over_misses", 32'(bus.misses), 32'd3);
    chk("over_score_held", 32'(bus.score), 32'd1);

    // Restart; correct and wrong key in the same cycle -> hit only
    tick(0, 1, '1);
    chk("restart_over", 32'(bus.game_over), 32'd0);
    for (int i = 0; i < 20 && m_phase != P_UP; i++) tick(0, 0, '1);
    chk("reach_up", 32'($onehot(bus.mole_led)), 32'd1);
    k = press_of(m_last);
    k[(m_last + 1) % NM] = 1'b0;
    tick(0, 0, k);
    chk("both_hit", 32'(bus.hit_pulse), 32'd1);
    chk("both_nomiss", 32'(bus.miss_pulse), 32'd0);
    chk("both_misses", 32'(bus.misses), 32'd0);

    // Build score to 5
    kprev = k;
    for (int i = 0; i < 400 && m_score < 5; i++) begin
      k = '1;
      if (m_phase == P_UP && kprev == '1) k = press_of(m_last);
      tick(0, 0, k);
      kprev = k;
    end
    chk("score5", 32'(bus.score), 32'd5);

    // Window at score 5 (shrinks to floor when speedup is built)
    tick(0, 0, '1);
    uplen = 0;
    for (int i = 0; i < 60 && !bus.miss_pulse; i++) begin
      tick(0, 0, '1);
      if (bus.mole_led != '0) uplen++;
    end
    chk("win_s5", 32'(uplen), 32'(win_for(5)));

    // Reset mid-UP with a correct press in flight
    for (int i = 0; i < 20 && m_phase != P_UP; i++) tick(0, 0, '1);
    tick(0, 0, '1);
    tick(1, 0, press_of(m_last));
    chk("rst_mid_score", 32'(bus.score), 32'd0);
    chk("rst_mid_led", 32'(bus.mole_led), 32'd0);
    chk("rst_mid_over", 32'(bus.game_over), 32'd0);
    chk("rst_mid_hit", 32'(bus.hit_pulse), 32'd0);
    tick(0, 0, '1);

    // Randomized play
    kprev = '1;
    for (int c = 0; c < 4000; c++) begin
      bit r, s;
      int a;
      r = ($urandom_range(0, 599) == 0);
      s = ($urandom_range(0, 29) == 0);
      a = $urandom_range(0, 99);
      k = kprev;
      if (a < 8 && m_phase == P_UP) k = press_of(m_last);
      else if (a < 12) k = press_of($urandom_range(0, NM - 1));
      else if (a < 14 && m_phase == P_UP) begin
        k = press_of(m_last);
        k[(m_last + 1) % NM] = 1'b0;
      end
      else if (a < 60) k = '1;
      tick(r, s, k);
      kprev = k;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
